// File: rtl/lsu_dccm_arb_pkg.sv
// Shared types for the DCCM port arbiter: FSM state encoding, grant vector
// and the priority pick used each cycle.
package lsu_dccm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      FORCE_DMA = 2'b01,
      FORCE_STB = 2'b10
   } lsu_dccm_arb_state_t;

   typedef struct packed {
      logic pipe;
      logic stbuf;
      logic dma;
   } arb_gnt_t;

   // Pipeline always wins; a forced window promotes its owner above the
   // normal store-buffer-full / DMA / drain order.
   function automatic arb_gnt_t arb_pick(
      input lsu_dccm_arb_state_t st,
      input logic                pipe_req,
      input logic                stbuf_req,
      input logic                stbuf_full,
      input logic                dma_req
   );
      arb_gnt_t g;
      g = '0;
      if (pipe_req)                             g.pipe  = 1'b1;
      else if ((st == FORCE_DMA) && dma_req)    g.dma   = 1'b1;
      else if ((st == FORCE_STB) && stbuf_req)  g.stbuf = 1'b1;
      else if (stbuf_full && stbuf_req)         g.stbuf = 1'b1;
      else if (dma_req)                         g.dma   = 1'b1;
      else if (stbuf_req)                       g.stbuf = 1'b1;
      return g;
   endfunction

endpackage

// File: rtl/lsu_dccm_arb_wcnt.sv
// Saturating DMA starvation counter; hit flags that the value about to be
// loaded equals the forced-window threshold.
module lsu_dccm_arb_wcnt #(
   parameter int unsigned CNT_W        = 4,
   parameter int unsigned DMA_MAX_WAIT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   input  logic             hold,
   output logic [CNT_W-1:0] cnt,
   output logic             hit
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (!hold) begin
         if (clr)
            w_cnt_nxt = '0;
         else if (inc && (r_cnt != CNT_MAX))
            w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_cnt <= '0;
      else     r_cnt <= w_cnt_nxt;
   end

   assign cnt = r_cnt;
   assign hit = (32'(w_cnt_nxt) == DMA_MAX_WAIT);

endmodule

// File: rtl/lsu_dccm_arb.sv
// DCCM port arbiter between the dc2 pipeline access, store-buffer drain and
// DMA, with forced one-access windows that block LSU issue at decode.
module lsu_dccm_arb
   import lsu_dccm_arb_pkg::*;
#(
   parameter int unsigned DMA_MAX_WAIT = 15,
   parameter int unsigned CNT_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lsu_freeze_dc3,
   input  logic             pipe_req_dc2,
   input  logic             stbuf_req,
   input  logic             stbuf_full,
   input  logic             dma_req,
   output logic             pipe_gnt,
   output logic             stbuf_gnt,
   output logic             dma_gnt,
   output logic             lsu_issue_block,
   output logic             arb_busy,
   output logic [CNT_W-1:0] dma_wait_cnt
);

   lsu_dccm_arb_state_t r_state;
   lsu_dccm_arb_state_t w_next_state;
   logic                r_issue_block;
   logic                r_stb_pend;
   logic                w_next_stb_pend;
   arb_gnt_t            w_gnt;
   logic                w_dma_miss;
   logic                w_stb_miss;
   logic                w_wait_hit;

   always_comb begin
      w_gnt = '0;
      if (!rst && !lsu_freeze_dc3)
         w_gnt = arb_pick(r_state, pipe_req_dc2, stbuf_req, stbuf_full, dma_req);
   end

   assign w_dma_miss = dma_req & ~w_gnt.dma;
   assign w_stb_miss = stbuf_full & ~w_gnt.stbuf;

   lsu_dccm_arb_wcnt #(
      .CNT_W        (CNT_W),
      .DMA_MAX_WAIT (DMA_MAX_WAIT)
   ) u_wcnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (w_dma_miss),
      .clr  (w_gnt.dma | ~dma_req),
      .hold (lsu_freeze_dc3),
      .cnt  (dma_wait_cnt),
      .hit  (w_wait_hit)
   );

   // A DMA window taken while the store buffer is also stuck remembers the
   // store-buffer window so it follows directly.
   always_comb begin
      w_next_state    = r_state;
      w_next_stb_pend = r_stb_pend;
      if (!lsu_freeze_dc3) begin
         case (r_state)
            IDLE: begin
               if (w_dma_miss && w_wait_hit) begin
                  w_next_state    = FORCE_DMA;
                  w_next_stb_pend = w_stb_miss;
               end else if (w_stb_miss) begin
                  w_next_state = FORCE_STB;
               end
            end
            FORCE_DMA: begin
               if (w_gnt.dma || !dma_req) begin
                  w_next_state    = r_stb_pend ? FORCE_STB : IDLE;
                  w_next_stb_pend = 1'b0;
               end
            end
            FORCE_STB: begin
               if (w_gnt.stbuf || !stbuf_req)
                  w_next_state = IDLE;
            end
            default: begin
               w_next_state    = IDLE;
               w_next_stb_pend = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_issue_block <= 1'b0;
         r_stb_pend    <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_issue_block <= (w_next_state != IDLE);
         r_stb_pend    <= w_next_stb_pend;
      end
   end

   assign pipe_gnt        = w_gnt.pipe;
   assign stbuf_gnt       = w_gnt.stbuf;
   assign dma_gnt         = w_gnt.dma;
   assign lsu_issue_block = r_issue_block;
   assign arb_busy        = pipe_req_dc2 | stbuf_req | dma_req |
                            (r_state != IDLE) | r_issue_block;

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Self-checking bench for lsu_dccm_arb: a vector table for single-cycle
// behaviour plus hand-built multi-cycle sequences for the forced windows.
module tb_lsu_dccm_arb;

   // {rst, freeze, pipe_req, stbuf_req, stbuf_full, dma_req}
   typedef struct packed {
      logic rst;
      logic frz;
      logic pipe;
      logic sreq;
      logic sfull;
      logic dreq;
   } in_t;

   // {pipe_gnt, stbuf_gnt, dma_gnt, issue_block, busy, wait_cnt}
   typedef struct packed {
      logic       pg;
      logic       sg;
      logic       dg;
      logic       blk;
      logic       busy;
      logic [3:0] cnt;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       lsu_freeze_dc3;
   logic       pipe_req_dc2;
   logic       stbuf_req;
   logic       stbuf_full;
   logic       dma_req;
   logic       pipe_gnt;
   logic       stbuf_gnt;
   logic       dma_gnt;
   logic       lsu_issue_block;
   logic       arb_busy;
   logic [3:0] dma_wait_cnt;

   int   checks;
   int   failures;
   out_t exp_q[$];
   vec_t tbl[15];

   lsu_dccm_arb #(
      .DMA_MAX_WAIT (15),
      .CNT_W        (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .lsu_freeze_dc3  (lsu_freeze_dc3),
      .pipe_req_dc2    (pipe_req_dc2),
      .stbuf_req       (stbuf_req),
      .stbuf_full      (stbuf_full),
      .dma_req         (dma_req),
      .pipe_gnt        (pipe_gnt),
      .stbuf_gnt       (stbuf_gnt),
      .dma_gnt         (dma_gnt),
      .lsu_issue_block (lsu_issue_block),
      .arb_busy        (arb_busy),
      .dma_wait_cnt    (dma_wait_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs after the falling edge, queue the expected
   // outputs, then sample and compare before the next rising edge.
   task automatic step(input string nm, input in_t vi, input out_t ve);
      out_t got;
      out_t exp_v;
      @(negedge clk);
      {rst, lsu_freeze_dc3, pipe_req_dc2, stbuf_req, stbuf_full, dma_req} = vi;
      exp_q.push_back(ve);
      #2;
      got = {pipe_gnt, stbuf_gnt, dma_gnt, lsu_issue_block, arb_busy, dma_wait_cnt};
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s: scoreboard empty, got=%b", nm, got);
      end else begin
         exp_v = exp_q.pop_front();
         if (got !== exp_v) begin
            failures++;
            $display("FAIL %s: got pg/sg/dg/blk/busy=%b cnt=%0d, required %b cnt=%0d",
                     nm, got[8:4], got.cnt, exp_v[8:4], exp_v.cnt);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      {rst, lsu_freeze_dc3, pipe_req_dc2, stbuf_req, stbuf_full, dma_req} = 6'b100000;
      repeat (2) @(posedge clk);

      tbl[0]  = '{i: in_t'(6'b101000), o: out_t'({5'b00001, 4'd0})}; // grants gated in reset
      tbl[1]  = '{i: in_t'(6'b000000), o: out_t'({5'b00000, 4'd0})};
      tbl[2]  = '{i: in_t'(6'b001000), o: out_t'({5'b10001, 4'd0})};
      tbl[3]  = '{i: in_t'(6'b000100), o: out_t'({5'b01001, 4'd0})};
      tbl[4]  = '{i: in_t'(6'b000001), o: out_t'({5'b00101, 4'd0})};
      tbl[5]  = '{i: in_t'(6'b000101), o: out_t'({5'b00101, 4'd0})}; // dma over drain
      tbl[6]  = '{i: in_t'(6'b000111), o: out_t'({5'b01001, 4'd0})}; // full drain over dma
      tbl[7]  = '{i: in_t'(6'b001001), o: out_t'({5'b10001, 4'd1})};
      tbl[8]  = '{i: in_t'(6'b000000), o: out_t'({5'b00000, 4'd2})}; // dma drop clears
      tbl[9]  = '{i: in_t'(6'b011101), o: out_t'({5'b00001, 4'd0})}; // freeze
      tbl[10] = '{i: in_t'(6'b010001), o: out_t'({5'b00001, 4'd0})}; // no count in freeze
      tbl[11] = '{i: in_t'(6'b000000), o: out_t'({5'b00000, 4'd0})};
      tbl[12] = '{i: in_t'(6'b000010), o: out_t'({5'b00000, 4'd0})}; // full, no drain req
      tbl[13] = '{i: in_t'(6'b000000), o: out_t'({5'b00011, 4'd0})}; // FORCE_STB, exits
      tbl[14] = '{i: in_t'(6'b000000), o: out_t'({5'b00000, 4'd0})};

      for (int n = 0; n < 15; n++)
         step($sformatf("tbl%0d", n), tbl[n].i, tbl[n].o);

      // DMA starved by a continuous pipeline stream
      for (int k = 1; k <= 15; k++)
         step($sformatf("ramp%0d", k), in_t'(6'b001001), out_t'({5'b10001, 4'(k-1)}));
      step("ramp_blk",   in_t'(6'b001001), out_t'({5'b10011, 4'd15}));
      step("ramp_dgnt",  in_t'(6'b000001), out_t'({5'b00111, 4'd15}));
      step("ramp_idle",  in_t'(6'b000000), out_t'({5'b00000, 4'd0}));

      // store buffer full behind the pipeline
      step("stb_enter",  in_t'(6'b001110), out_t'({5'b10001, 4'd0}));
      step("stb_blk",    in_t'(6'b001110), out_t'({5'b10011, 4'd0}));
      step("stb_gnt",    in_t'(6'b000110), out_t'({5'b01011, 4'd0}));
      step("stb_idle",   in_t'(6'b000000), out_t'({5'b00000, 4'd0}));

      // DMA threshold and store-buffer full in the same cycle
      for (int k = 1; k <= 14; k++)
         step($sformatf("both_ramp%0d", k), in_t'(6'b001001), out_t'({5'b10001, 4'(k-1)}));
      step("both_hit",   in_t'(6'b001111), out_t'({5'b10001, 4'd14}));
      step("both_dgnt",  in_t'(6'b000111), out_t'({5'b00111, 4'd15}));
      step("both_sgnt",  in_t'(6'b000111), out_t'({5'b01011, 4'd0}));
      step("both_idle",  in_t'(6'b000000), out_t'({5'b00000, 4'd1}));
      step("both_clr",   in_t'(6'b000000), out_t'({5'b00000, 4'd0}));

      // freeze while in FORCE_DMA at saturation
      for (int k = 1; k <= 15; k++)
         step($sformatf("frz_ramp%0d", k), in_t'(6'b001001), out_t'({5'b10001, 4'(k-1)}));
      step("frz_blk",    in_t'(6'b001001), out_t'({5'b10011, 4'd15}));
      for (int k = 1; k <= 5; k++)
         step($sformatf("frz_hold%0d", k), in_t'(6'b010001), out_t'({5'b00011, 4'd15}));
      step("frz_dgnt",   in_t'(6'b000001), out_t'({5'b00111, 4'd15}));
      step("frz_idle",   in_t'(6'b000000), out_t'({5'b00000, 4'd0}));

      // reset in the middle of a store-buffer window
      step("rst_enter",  in_t'(6'b001111), out_t'({5'b10001, 4'd0}));
      step("rst_blk",    in_t'(6'b001111), out_t'({5'b10011, 4'd1}));
      step("rst_assert", in_t'(6'b101111), out_t'({5'b00011, 4'd2}));
      step("rst_after",  in_t'(6'b001101), out_t'({5'b10001, 4'd0}));
      step("rst_dma",    in_t'(6'b000101), out_t'({5'b00101, 4'd1}));
      step("rst_stb",    in_t'(6'b000100), out_t'({5'b01001, 4'd0}));
      step("rst_idle",   in_t'(6'b000000), out_t'({5'b00000, 4'd0}));

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
